// File: rtl/cpu_pkg.sv
// Shared opcode constants, ALU control encodings and the control bundle type.
package cpu_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD      = 3'b000,
    ALU_BRANCH   = 3'b001,
    ALU_OP_IMM   = 3'b010,
    ALU_OP_REG   = 3'b011,
    ALU_PASS_IMM = 3'b100,
    ALU_MULDIV   = 3'b101
  } alu_ctrl_e;

  typedef struct packed {
    logic       valid;
    alu_ctrl_e  alu_control;
    logic       alu_2_src;
    logic       reg_write;
    logic       is_branch;
    logic       is_jump;
    logic       mem_write;
    logic       load_mem;
    logic       mem_sign_extend;
    logic       illegal;
    logic [1:0] mem_width;
    logic [4:0] rd;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decode: control bundle plus register-read flags.
import cpu_pkg::*;

module ctrl_decode #(
  parameter int unsigned EN_MEXT = 1
) (
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o,
  output logic         rs1_used_o,
  output logic         rs2_used_o,
  output logic [4:0]   rs1_o,
  output logic [4:0]   rs2_o,
  output logic         is_muldiv_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1_o  = instr_i[19:15];
  assign rs2_o  = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  logic legal;
  logic writes_rd;

  // Opcode decode; illegal encodings collapse to a flag-only bundle.
  always_comb begin
    ctrl_o      = '0;
    rs1_used_o  = 1'b0;
    rs2_used_o  = 1'b0;
    is_muldiv_o = 1'b0;
    legal       = 1'b1;
    writes_rd   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl_o.alu_control = ALU_ADD;
        ctrl_o.alu_2_src   = 1'b1;
        ctrl_o.load_mem    = 1'b1;
        ctrl_o.mem_width   = funct3[1:0];
        rs1_used_o         = 1'b1;
        writes_rd          = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.alu_control = ALU_ADD;
        ctrl_o.alu_2_src   = 1'b1;
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.mem_width   = funct3[1:0];
        rs1_used_o         = 1'b1;
        rs2_used_o         = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.alu_control = ALU_BRANCH;
        ctrl_o.is_branch   = 1'b1;
        rs1_used_o         = 1'b1;
        rs2_used_o         = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_o.alu_control = ALU_OP_IMM;
        ctrl_o.alu_2_src   = 1'b1;
        rs1_used_o         = 1'b1;
        writes_rd          = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == FUNCT7_MULDIV) begin
          if (EN_MEXT != 0) begin
            ctrl_o.alu_control = ALU_MULDIV;
            is_muldiv_o        = 1'b1;
          end else begin
            legal = 1'b0;
          end
        end else begin
          ctrl_o.alu_control = ALU_OP_REG;
        end
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
        writes_rd  = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.alu_control = ALU_PASS_IMM;
        ctrl_o.alu_2_src   = 1'b1;
        writes_rd          = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.alu_control = ALU_ADD;
        ctrl_o.alu_2_src   = 1'b1;
        writes_rd          = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.alu_control = ALU_ADD;
        ctrl_o.alu_2_src   = 1'b1;
        ctrl_o.is_jump     = 1'b1;
        writes_rd          = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.alu_control = ALU_ADD;
        ctrl_o.alu_2_src   = 1'b1;
        ctrl_o.is_jump     = 1'b1;
        rs1_used_o         = 1'b1;
        writes_rd          = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
      rs1_used_o     = 1'b0;
      rs2_used_o     = 1'b0;
      is_muldiv_o    = 1'b0;
    end else begin
      ctrl_o.mem_sign_extend = ~funct3[2];
      ctrl_o.reg_write       = writes_rd && (rd != 5'd0);
    end
    ctrl_o.rd = rd;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Decode stage register with load-use and mul/div occupancy stalls.
import cpu_pkg::*;

module ctrl_pipe #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned EN_MEXT       = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  output logic        ctrl_valid_o,
  output logic [2:0]  alu_control_o,
  output logic        alu_2_src_o,
  output logic        reg_write_o,
  output logic        is_branch_o,
  output logic        is_jump_o,
  output logic        mem_write_o,
  output logic        load_mem_o,
  output logic        mem_sign_extend_o,
  output logic        illegal_o,
  output logic [1:0]  mem_width_o,
  output logic [4:0]  rd_o,
  output logic        busy_o
);

  localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

  ctrl_bundle_t dec;
  logic         rs1_used;
  logic         rs2_used;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         is_muldiv;

  ctrl_decode #(
    .EN_MEXT (EN_MEXT)
  ) u_decode (
    .instr_i     (instr_i),
    .ctrl_o      (dec),
    .rs1_used_o  (rs1_used),
    .rs2_used_o  (rs2_used),
    .rs1_o       (rs1),
    .rs2_o       (rs2),
    .is_muldiv_o (is_muldiv)
  );

  ctrl_bundle_t ctrl_q, ctrl_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         load_use;
  logic         busy;
  logic         accept;

  // Hazard detection and handshake.
  always_comb begin
    load_use = ctrl_q.valid && ctrl_q.load_mem && (ctrl_q.rd != 5'd0) &&
               instr_valid_i &&
               ((rs1_used && (rs1 == ctrl_q.rd)) || (rs2_used && (rs2 == ctrl_q.rd)));
    busy          = (cnt_q != 4'd0);
    instr_ready_o = ~flush_i & ~load_use & ~busy;
    accept        = instr_valid_i & instr_ready_o;
  end

  // Next bundle and mul/div occupancy counter; flush wins over everything.
  always_comb begin
    ctrl_d = '0;
    cnt_d  = cnt_q;
    if (accept) begin
      ctrl_d       = dec;
      ctrl_d.valid = 1'b1;
    end
    if (flush_i) begin
      cnt_d = '0;
    end else if (accept && is_muldiv) begin
      cnt_d = MULDIV_LOAD;
    end else if (busy) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Stage registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ctrl_valid_o      = ctrl_q.valid;
  assign alu_control_o     = ctrl_q.alu_control;
  assign alu_2_src_o       = ctrl_q.alu_2_src;
  assign reg_write_o       = ctrl_q.reg_write;
  assign is_branch_o       = ctrl_q.is_branch;
  assign is_jump_o         = ctrl_q.is_jump;
  assign mem_write_o       = ctrl_q.mem_write;
  assign load_mem_o        = ctrl_q.load_mem;
  assign mem_sign_extend_o = ctrl_q.mem_sign_extend;
  assign illegal_o         = ctrl_q.illegal;
  assign mem_width_o       = ctrl_q.mem_width;
  assign rd_o              = ctrl_q.rd;
  assign busy_o            = busy;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; a second instance has RV32M decode disabled.
module tb_ctrl_pipe;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        flush;

  logic        ready, cvalid, alu2, regw, isbr, isjmp, memw, ldm, sext, ill, busy;
  logic [2:0]  aluc;
  logic [1:0]  mwidth;
  logic [4:0]  rd;

  logic        n_ready, n_cvalid, n_alu2, n_regw, n_isbr, n_isjmp, n_memw, n_ldm, n_sext, n_ill, n_busy;
  logic [2:0]  n_aluc;
  logic [1:0]  n_mwidth;
  logic [4:0]  n_rd;

  int unsigned vectors;
  int unsigned miscompares;

  ctrl_pipe #(.MULDIV_CYCLES(4), .EN_MEXT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(ready), .flush_i(flush), .ctrl_valid_o(cvalid),
    .alu_control_o(aluc), .alu_2_src_o(alu2), .reg_write_o(regw),
    .is_branch_o(isbr), .is_jump_o(isjmp), .mem_write_o(memw), .load_mem_o(ldm),
    .mem_sign_extend_o(sext), .illegal_o(ill), .mem_width_o(mwidth), .rd_o(rd),
    .busy_o(busy)
  );

  ctrl_pipe #(.MULDIV_CYCLES(4), .EN_MEXT(0)) dut_nom (
    .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(n_ready), .flush_i(flush), .ctrl_valid_o(n_cvalid),
    .alu_control_o(n_aluc), .alu_2_src_o(n_alu2), .reg_write_o(n_regw),
    .is_branch_o(n_isbr), .is_jump_o(n_isjmp), .mem_write_o(n_memw), .load_mem_o(n_ldm),
    .mem_sign_extend_o(n_sext), .illegal_o(n_ill), .mem_width_o(n_mwidth), .rd_o(n_rd),
    .busy_o(n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    flush = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cvalid", {31'd0, cvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_cvalid", {31'd0, cvalid}, 32'd0);

    // ADDI x1,x0,5
    instr_valid = 1'b1;
    instr = 32'h00500093;
    #1 check("addi_ready", {31'd0, ready}, 32'd1);
    tick();
    check("addi_cvalid", {31'd0, cvalid}, 32'd1);
    check("addi_alu", {29'd0, aluc}, 32'd2);
    check("addi_alu2", {31'd0, alu2}, 32'd1);
    check("addi_regw", {31'd0, regw}, 32'd1);
    check("addi_rd", {27'd0, rd}, 32'd1);
    check("addi_ill", {31'd0, ill}, 32'd0);

    // LW x2,0(x1)
    instr = 32'h0000A103;
    tick();
    check("lw_load", {31'd0, ldm}, 32'd1);
    check("lw_regw", {31'd0, regw}, 32'd1);
    check("lw_rd", {27'd0, rd}, 32'd2);
    check("lw_width", {30'd0, mwidth}, 32'd2);
    check("lw_sext", {31'd0, sext}, 32'd1);
    check("lw_alu", {29'd0, aluc}, 32'd0);

    // ADD x3,x2,x0 -> load-use stall, bubble, then ADD
    instr = 32'h000101B3;
    #1 check("lu_ready", {31'd0, ready}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, cvalid}, 32'd0);
    check("lu_bubble_regw", {31'd0, regw}, 32'd0);
    check("lu_ready_back", {31'd0, ready}, 32'd1);
    tick();
    check("add_cvalid", {31'd0, cvalid}, 32'd1);
    check("add_alu", {29'd0, aluc}, 32'd3);
    check("add_alu2", {31'd0, alu2}, 32'd0);
    check("add_rd", {27'd0, rd}, 32'd3);

    // MUL x4,x1,x2 -> three busy cycles
    instr = 32'h02208233;
    #1 check("mul_ready", {31'd0, ready}, 32'd1);
    tick();
    check("mul_cvalid", {31'd0, cvalid}, 32'd1);
    check("mul_alu", {29'd0, aluc}, 32'd5);
    check("mul_rd", {27'd0, rd}, 32'd4);
    check("nom_mul_ill", {31'd0, n_ill}, 32'd1);
    check("nom_mul_regw", {31'd0, n_regw}, 32'd0);
    check("nom_mul_memw", {31'd0, n_memw}, 32'd0);
    check("nom_mul_cvalid", {31'd0, n_cvalid}, 32'd1);
    instr = 32'h00500293; // ADDI x5,x0,5 waiting behind the MUL
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mul_busy", {31'd0, busy}, 32'd1);
      check("mul_stall", {31'd0, ready}, 32'd0);
      tick();
      check("mul_stall_bubble", {31'd0, cvalid}, 32'd0);
      check("mul_alu_once", {29'd0, aluc}, 32'd0);
    end
    check("mul_done_busy", {31'd0, busy}, 32'd0);
    check("mul_done_ready", {31'd0, ready}, 32'd1);
    tick();
    check("addi5_cvalid", {31'd0, cvalid}, 32'd1);
    check("addi5_rd", {27'd0, rd}, 32'd5);

    // Flush during a muldiv stall
    instr = 32'h02208233;
    tick();
    check("fl_busy_pre", {31'd0, busy}, 32'd1);
    instr = 32'h00500293;
    flush = 1'b1;
    #1 check("fl_ready", {31'd0, ready}, 32'd0);
    tick();
    flush = 1'b0;
    check("fl_busy", {31'd0, busy}, 32'd0);
    check("fl_cvalid", {31'd0, cvalid}, 32'd0);
    #1 check("fl_ready_after", {31'd0, ready}, 32'd1);

    // Illegal opcode 1111111, rd=1
    instr = 32'h000000FF;
    tick();
    check("ill_cvalid", {31'd0, cvalid}, 32'd1);
    check("ill_flag", {31'd0, ill}, 32'd1);
    check("ill_regw", {31'd0, regw}, 32'd0);
    check("ill_memw", {31'd0, memw}, 32'd0);
    check("ill_jump", {31'd0, isjmp}, 32'd0);

    // SW x2,0(x1)
    instr = 32'h0020A023;
    tick();
    check("sw_memw", {31'd0, memw}, 32'd1);
    check("sw_regw", {31'd0, regw}, 32'd0);
    check("sw_alu2", {31'd0, alu2}, 32'd1);
    check("sw_ill", {31'd0, ill}, 32'd0);

    // JAL x1
    instr = 32'h000000EF;
    tick();
    check("jal_jump", {31'd0, isjmp}, 32'd1);
    check("jal_regw", {31'd0, regw}, 32'd1);

    // BEQ x1,x2
    instr = 32'h00208063;
    tick();
    check("beq_branch", {31'd0, isbr}, 32'd1);
    check("beq_alu", {29'd0, aluc}, 32'd1);
    check("beq_alu2", {31'd0, alu2}, 32'd0);
    check("beq_regw", {31'd0, regw}, 32'd0);

    // No valid input -> bubble
    instr_valid = 1'b0;
    tick();
    check("idle_bubble", {31'd0, cvalid}, 32'd0);
    check("idle_branch", {31'd0, isbr}, 32'd0);

    // Reset asserted mid-muldiv
    instr_valid = 1'b1;
    instr = 32'h02208233;
    tick();
    check("rm_busy_pre", {31'd0, busy}, 32'd1);
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rm_cvalid", {31'd0, cvalid}, 32'd0);
    check("rm_alu", {29'd0, aluc}, 32'd0);
    check("rm_rd", {27'd0, rd}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rm_busy_after", {31'd0, busy}, 32'd0);
    check("rm_ready_after", {31'd0, ready}, 32'd1);
    instr_valid = 1'b1;
    instr = 32'h00500093;
    tick();
    check("rm_addi_cvalid", {31'd0, cvalid}, 32'd1);
    instr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, meaning the cycles a mul/div occupies execute (legal range 1..15).
REQ-002 SHALL have parameter EN_MEXT, default 1, meaning RV32M decode is enabled; 0 makes M opcodes illegal.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port instr_valid_i  in  1  instr_i holds a fetched instruction.
REQ-006 SHALL have port instr_i  in  32  instruction word.
REQ-007 SHALL have port instr_ready_o  out  1  the block accepts instr_i this cycle.
REQ-008 SHALL have port flush_i  in  1  taken branch/jump in execute; kill the decoded instruction.
REQ-009 SHALL have port ctrl_valid_o  out  1  registered control bundle is valid for execute.
REQ-010 SHALL have port alu_control_o  out  3  000 add, 001 branch compare, 010 op-imm, 011 op-reg, 100 pass-imm (LUI), 101 muldiv.
REQ-011 SHALL have ports alu_2_src_o, reg_write_o, is_branch_o, is_jump_o, mem_write_o, load_mem_o, mem_sign_extend_o, illegal_o  out  1 each  registered control flags.
REQ-012 SHALL have port mem_width_o  out  2  funct3[1:0] of a load/store.
REQ-013 SHALL have port rd_o  out  5  destination register of the registered instruction.
REQ-014 SHALL have port busy_o  out  1  mul/div occupancy counter is nonzero.

Function
REQ-015 SHALL decode LOAD, STORE, BRANCH, OP-IMM, OP, LUI, AUIPC, JAL and JALR; any other opcode, or an M opcode (OP with funct7=0000001) when EN_MEXT=0, is illegal.
REQ-016 SHALL accept an instruction on a cycle where instr_valid_i and instr_ready_o are both 1; the bundle appears on the outputs exactly 1 cycle later with ctrl_valid_o=1.
REQ-017 SHALL drive ctrl_valid_o=0 on the cycle after any cycle with no accept (bubble); a bubble bundle has every flag 0.
REQ-018 SHALL set reg_write_o=0 for STORE, BRANCH, illegal, and any instruction with rd=0.
REQ-019 SHALL set alu_2_src_o=1 for all decoded opcodes except OP and BRANCH; mem_sign_extend_o = ~funct3[2].
REQ-020 SHALL set is_jump_o=1 for JAL and JALR.
REQ-021 SHALL, for an illegal instruction, assert illegal_o with ctrl_valid_o=1 and force reg_write_o, mem_write_o, load_mem_o, is_branch_o and is_jump_o to 0.
REQ-022 SHALL detect load-use: when the registered bundle is valid with load_mem_o=1 and rd_o!=0, and the incoming instruction reads rs1 or rs2 equal to rd_o, drive instr_ready_o=0 for exactly that cycle.
REQ-023 SHALL treat rs2 as read only by OP, STORE and BRANCH, and rs1 as read by all opcodes except LUI, AUIPC and JAL.
REQ-024 SHALL, on accepting an M instruction, load a 4-bit counter with MULDIV_CYCLES-1; while the counter is nonzero, busy_o=1 and instr_ready_o=0, and the counter decrements each cycle.
REQ-025 SHALL, with MULDIV_CYCLES=1, never assert busy_o or stall.
REQ-026 SHALL, when flush_i=1, drive instr_ready_o=0, clear the counter and produce a bubble the next cycle; flush takes priority over load-use and muldiv stalls.
REQ-027 SHALL drive instr_ready_o = ~flush_i & ~load_use & ~busy_o, combinationally.

Reset
REQ-028 SHALL, while rst_n_i=0, clear every registered output (ctrl_valid_o, all flags, alu_control_o, mem_width_o, rd_o) and the counter to 0, asynchronously.
REQ-029 SHALL, if reset asserts mid-muldiv, abandon the operation; busy_o=0 from the first cycle after release.

Structure
REQ-030 SHALL take opcode constants, funct7 M value and the alu_control encodings from a shared package cpu_pkg.
REQ-031 SHALL place pure combinational decode in one sub-module ctrl_decode (instr in, unregistered bundle plus rs-used flags out); ctrl_pipe holds the registers, hazard logic and counter.

Verification
REQ-032 SHALL cover: reset release, then ADDI x1,x0,5 valid -> next cycle ctrl_valid_o=1, alu_control_o=010, alu_2_src_o=1, reg_write_o=1, rd_o=1.
REQ-033 SHALL cover: LW x2,0(x1), then ADD x3,x2,x0 -> instr_ready_o=0 for one cycle, one bubble, ADD bundle follows.
REQ-034 SHALL cover: MUL x4,x1,x2 with MULDIV_CYCLES=4 -> busy_o=1 and instr_ready_o=0 for 3 cycles, alu_control_o=101 once.
REQ-035 SHALL cover: flush_i=1 during a muldiv stall -> busy_o=0 next cycle, ctrl_valid_o=0.
REQ-036 SHALL cover: opcode 1111111, and MUL with EN_MEXT=0 -> illegal_o=1, reg_write_o=0, mem_write_o=0.
REQ-037 SHALL cover: rst_n_i low mid-muldiv -> all outputs 0 immediately, no stall after release.
